uart_top: RTL and testbench

- 8N1 UART transmitter and receiver in one block, with the serial output looped internally back into the receiver.
- A byte presented with a start strobe is serialised on tx, then deserialised by the receiver and reported on data_out with a one-cycle data_valid pulse.
- Used as a self-test / loopback top for the UART datapath.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx.sv | 110 +++++++++++
 rtl/uart_tx.sv | 110 +++++++++++
 rtl/uart_top.sv | 46 ++++
 tb/tb_uart_top.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared 8N1 frame constants, FSM encodings and the bit-period helper for the UART loopback slice.
// Pure declarations: no timing and no flow control of its own.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 deserialiser with 2-flop synchroniser and mid-bit sampling; data_valid ~9.5 bit periods + 3 after the start edge.
// No backpressure: each good frame overwrites data_out; framing errors are dropped silently.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       BIT_MAX  = 3'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Re-check half a bit in so a short low glitch is not taken as a frame.
        if (cnt_q == HALF_MAX) begin
          cnt_d = '0;
          if (!sync2_q) begin
            state_d = RX_DATA;
            bit_d   = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_MAX) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 serialiser: tx falls one cycle after start is accepted; busy spans 10 bit periods per frame.
// start is ignored while busy, except in the last stop cycle, where it chains the next frame with no gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_MAX = 3'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_START;
          shift_d = data_in;
          cnt_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      TX_START: begin
        if (cnt_q == CNT_MAX) begin
          state_d = TX_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (bit_q == BIT_MAX) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          // A held start request goes straight into the next start bit.
          if (start) begin
            state_d = TX_START;
            shift_d = data_in;
            tx_d    = 1'b0;
          end else begin
            state_d = TX_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: rtl/uart_top.sv
// UART loopback: tx is fed straight back into the receiver; data_valid lands ~9.5 bit periods + 3 after start.
// start is ignored while busy; a held start chains frames back-to-back.
module uart_top
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);

  logic tx_line;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data_in(data_in),
    .tx     (tx_line),
    .busy   (busy)
  );

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (tx_line),
    .data_out  (data_out),
    .data_valid(data_valid)
  );

  assign tx = tx_line;

endmodule

// File: tb/tb_uart_top.sv
// Directed loopback bench: a 10-clock/bit instance for the main cases plus one frame at default rates.
module tb_uart_top;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       f_rst, f_start, f_tx, f_dv, f_busy;
  logic [7:0] f_din, f_dout;
  logic       d_rst, d_start, d_tx, d_dv, d_busy;
  logic [7:0] d_din, d_dout;

  uart_top #(
    .CLOCK_FREQ(1000000),
    .BAUD_RATE (100000)
  ) u_fast (
    .clk       (clk),
    .rst       (f_rst),
    .start     (f_start),
    .data_in   (f_din),
    .tx        (f_tx),
    .data_out  (f_dout),
    .data_valid(f_dv),
    .busy      (f_busy)
  );

  uart_top u_dflt (
    .clk       (clk),
    .rst       (d_rst),
    .start     (d_start),
    .data_in   (d_din),
    .tx        (d_tx),
    .data_out  (d_dout),
    .data_valid(d_dv),
    .busy      (d_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] f_rx[$];
  int f_dv_cnt = 0, f_dv_cyc = 0;
  int d_dv_cnt = 0, d_dv_cyc = 0;

  always @(negedge clk) begin
    if (f_dv === 1'b1) begin
      f_rx.push_back(f_dout);
      f_dv_cnt++;
      f_dv_cyc = cyc;
    end
    if (d_dv === 1'b1) begin
      d_dv_cnt++;
      d_dv_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one fast frame and checks every cycle of tx and busy against the 8N1 pattern.
  task automatic fast_frame(input logic [7:0] b, input logic [7:0] b_after,
                            input string tag, output int acc);
    logic [9:0] frame;
    frame   = {1'b1, b, 1'b0};
    f_din   = b;
    f_start = 1'b1;
    tick(1);
    acc     = cyc;
    f_start = 1'b0;
    f_din   = b_after;
    for (int i = 0; i < 100; i++) begin
      check({tag, "_tx"}, f_tx, frame[i/10]);
      check({tag, "_busy"}, f_busy, 1);
      tick(1);
    end
    check({tag, "_busy_end"}, f_busy, 0);
    check({tag, "_tx_end"}, f_tx, 1);
  endtask

  initial begin
    int acc, n0, busy_low;
    logic [9:0] dframe;

    f_rst = 1'b1; f_start = 1'b0; f_din = 8'h00;
    d_rst = 1'b1; d_start = 1'b0; d_din = 8'h00;
    tick(3);
    check("rst_tx", f_tx, 1);
    check("rst_busy", f_busy, 0);
    check("rst_dv", f_dv, 0);
    check("rst_dout", f_dout, 8'h00);
    check("rst_d_tx", d_tx, 1);
    check("rst_d_busy", d_busy, 0);
    f_rst = 1'b0;
    d_rst = 1'b0;
    tick(2);

    // Single frame 0xAA.
    n0 = f_dv_cnt;
    fast_frame(8'hAA, 8'hAA, "aa", acc);
    check("aa_dv_cnt", f_dv_cnt - n0, 1);
    check("aa_dout", f_dout, 8'hAA);
    check("aa_latency", f_dv_cyc - acc, 98);

    // Back-to-back 0x00 then 0xFF with start held.
    tick(3);
    n0 = f_dv_cnt;
    busy_low = 0;
    f_din = 8'h00;
    f_start = 1'b1;
    tick(1);
    acc = cyc;
    f_din = 8'hFF;
    for (int i = 0; i < 100; i++) begin
      if (f_busy !== 1'b1) busy_low++;
      tick(1);
    end
    check("b2b_tx_start2", f_tx, 0);
    check("b2b_busy_mid", f_busy, 1);
    f_start = 1'b0;
    for (int i = 100; i < 200; i++) begin
      if (f_busy !== 1'b1) busy_low++;
      tick(1);
    end
    check("b2b_busy_low_cycles", busy_low, 0);
    check("b2b_busy_end", f_busy, 0);
    check("b2b_dv_cnt", f_dv_cnt - n0, 2);
    check("b2b_byte1", f_rx[$-1], 8'h00);
    check("b2b_byte2", f_rx[$], 8'hFF);
    check("b2b_latency2", f_dv_cyc - acc, 198);

    // start while busy is ignored.
    tick(3);
    n0 = f_dv_cnt;
    f_din = 8'hC3;
    f_start = 1'b1;
    tick(1);
    f_start = 1'b0;
    tick(30);
    f_din = 8'h55;
    f_start = 1'b1;
    tick(1);
    f_start = 1'b0;
    check("ign_busy", f_busy, 1);
    tick(69);
    check("ign_busy_end", f_busy, 0);
    check("ign_tx_end", f_tx, 1);
    tick(5);
    check("ign_dv_cnt", f_dv_cnt - n0, 1);
    check("ign_dout", f_dout, 8'hC3);

    // Reset mid-frame aborts both sides.
    tick(3);
    n0 = f_dv_cnt;
    f_din = 8'h5A;
    f_start = 1'b1;
    tick(1);
    f_start = 1'b0;
    tick(45);
    f_rst = 1'b1;
    tick(1);
    check("abort_tx", f_tx, 1);
    check("abort_busy", f_busy, 0);
    check("abort_dv", f_dv, 0);
    f_rst = 1'b0;
    tick(150);
    check("abort_dv_cnt", f_dv_cnt - n0, 0);
    check("abort_busy_after", f_busy, 0);

    // data_in changes after acceptance do not affect the frame.
    tick(3);
    n0 = f_dv_cnt;
    fast_frame(8'h96, 8'h0F, "hold", acc);
    check("hold_dv_cnt", f_dv_cnt - n0, 1);
    check("hold_dout", f_dout, 8'h96);

    // One frame at default rates (5208 clocks/bit), sampled mid-bit.
    dframe = {1'b1, 8'hA5, 1'b0};
    n0 = d_dv_cnt;
    d_din = 8'hA5;
    d_start = 1'b1;
    tick(1);
    acc = cyc;
    d_start = 1'b0;
    d_din = 8'h0F;
    for (int k = 0; k < 10; k++) begin
      tick(k == 0 ? 2604 : 5208);
      check("dflt_tx", d_tx, dframe[k]);
      check("dflt_busy", d_busy, 1);
    end
    tick(2603);
    check("dflt_busy_last", d_busy, 1);
    tick(1);
    check("dflt_busy_end", d_busy, 0);
    check("dflt_dv_cnt", d_dv_cnt - n0, 1);
    check("dflt_dout", d_dout, 8'hA5);
    check("dflt_latency", d_dv_cyc - acc, 49479);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
